rgb_window_gen: RTL and testbench

RGB_WINDOW_GEN -- requirements
Module: rgb_window_gen

---
 rtl/window_pkg.sv | 20 ++
 rtl/line_buffer.sv | 26 ++
 rtl/rgb_window_gen.sv | 165 ++++++++++++++++
 tb/tb_rgb_window_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared widths, FSM state type and tap ordering for the 3x3 RGB window generator.
package window_pkg;

    localparam int PIX_W    = 24;
    localparam int WIN_TAPS = 9;
    localparam int WIN_W    = PIX_W * WIN_TAPS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Tap index 0..8 = a..i row-major; a sits in the top slice, i in the bottom slice.
    function automatic int tap_lsb(input int tap);
        return (WIN_TAPS - 1 - tap) * PIX_W;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: combinational read and write at the same address, read-before-write.
module line_buffer
    import window_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Store the accepted word; the read above still sees the previous contents this cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/rgb_window_gen.sv
// Streams raster RGB pixels into a 3x3 interior window, one window per accepted pixel
// once two full lines are buffered; frame_done marks the frame's last window.
module rgb_window_gen
    import window_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [WIN_W-1:0] RGB_window,
    output logic             out_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t                        r_state;
    state_t                        w_next_state;
    logic [CW-1:0]                 r_col;
    logic [RW-1:0]                 r_row;
    logic                          w_accept;
    logic                          w_sof_acc;
    logic                          w_emit;
    logic                          w_enter_done;
    logic [CW-1:0]                 w_addr;
    logic [PIX_W-1:0]              w_lb1_rd;
    logic [PIX_W-1:0]              w_lb2_rd;
    logic [2:0][2:0][PIX_W-1:0]    r_win;
    logic [2:0][2:0][PIX_W-1:0]    w_win_next;
    logic [WIN_W-1:0]              w_window_next;
    logic [WIN_W-1:0]              r_window;
    logic                          r_out_valid;
    logic                          r_frame_done;

    // Acceptance, restart detection and next-state selection.
    always_comb begin
        w_next_state = r_state;
        w_enter_done = 1'b0;
        w_sof_acc    = !rst && in_valid && in_sof;
        w_accept     = !rst && in_valid &&
                       (in_sof || (r_state == ST_FILL) || (r_state == ST_RUN));
        case (r_state)
            ST_IDLE: begin
                if (w_sof_acc) w_next_state = ST_FILL;
                else           w_next_state = ST_IDLE;
            end
            ST_FILL: begin
                if (w_sof_acc)
                    w_next_state = ST_FILL;
                else if (w_accept && (r_row == RW'(1)) && (r_col == COL_LAST))
                    w_next_state = ST_RUN;
                else
                    w_next_state = ST_FILL;
            end
            ST_RUN: begin
                if (w_sof_acc) begin
                    w_next_state = ST_FILL;
                end else if (w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST)) begin
                    w_next_state = ST_DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_sof_acc) w_next_state = ST_FILL;
                else           w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // A restarting pixel is (0,0) regardless of where the counters stood.
        w_addr = w_sof_acc ? CW'(0) : r_col;
        w_emit = w_accept && !w_sof_acc && (r_row >= RW'(2)) && (r_col >= CW'(2));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= CW'(0);
            r_row <= RW'(0);
        end else if (w_sof_acc) begin
            r_col <= CW'(1);
            r_row <= RW'(0);
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= CW'(0);
                r_row <= (r_row == ROW_LAST) ? RW'(0) : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
                r_row <= r_row;
            end
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .i_clk   (clk),
        .i_we    (w_accept),
        .i_addr  (w_addr),
        .i_wdata (in_pixel),
        .o_rdata (w_lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
        .i_clk   (clk),
        .i_we    (w_accept),
        .i_addr  (w_addr),
        .i_wdata (w_lb1_rd),
        .o_rdata (w_lb2_rd)
    );

    // Shift the window left by one column and pack it into tap order.
    always_comb begin
        w_win_next    = r_win;
        w_window_next = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                w_win_next[r][c] = r_win[r][c+1];
            end
        end
        w_win_next[0][2] = w_lb2_rd;
        w_win_next[1][2] = w_lb1_rd;
        w_win_next[2][2] = in_pixel;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_window_next[tap_lsb(3*r + c) +: PIX_W] = w_win_next[r][c];
            end
        end
    end

    // Window shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win        <= '0;
            r_window     <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_emit;
            r_frame_done <= w_enter_done;
            r_win        <= w_accept ? w_win_next    : r_win;
            r_window     <= w_emit   ? w_window_next : r_window;
        end
    end

    assign RGB_window = r_window;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_rgb_window_gen.sv
// Directed bench for rgb_window_gen on a 4x4 image with an image-array reference model.
module tb_rgb_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_sof;
    logic [23:0]  in_pixel;
    logic [215:0] RGB_window;
    logic         out_valid;
    logic         frame_done;

    rgb_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .RGB_window (RGB_window),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks;
    int           errors;
    logic         chk_en;
    logic         exp_valid, exp_done;
    logic [215:0] exp_win;
    logic         nx_valid, nx_done;
    logic [215:0] nx_win;
    logic         mdl_active;
    int           mdl_r, mdl_c;
    logic [23:0]  img [H][W];
    int           n_win_seen, n_done_seen;
    logic [215:0] first_win, last_win;

    task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pixel(input int r, input int c, input logic [23:0] x);
        return {8'(r), 8'(c), 8'(4*r + c)} ^ x;
    endfunction

    // One clock: check the outputs of the previous edge, drive, advance the model.
    task automatic step(input logic r, input logic v, input logic s, input logic [23:0] p);
        @(negedge clk);
        if (chk_en) begin
            chk("out_valid",  {215'd0, out_valid},  {215'd0, exp_valid});
            chk("frame_done", {215'd0, frame_done}, {215'd0, exp_done});
            chk("RGB_window", RGB_window, exp_win);
            if (out_valid === 1'b1) begin
                n_win_seen++;
                if (n_win_seen == 1) first_win = RGB_window;
                last_win = RGB_window;
            end
            if (frame_done === 1'b1) n_done_seen++;
        end
        rst = r; in_valid = v; in_sof = s; in_pixel = p;
        nx_valid = 1'b0;
        nx_done  = 1'b0;
        nx_win   = exp_win;
        if (r) begin
            mdl_active = 1'b0;
            nx_win     = '0;
        end else if (v && (s || mdl_active)) begin
            if (s) begin
                mdl_active = 1'b1;
                mdl_r = 0;
                mdl_c = 0;
            end
            img[mdl_r][mdl_c] = p;
            if (mdl_r >= 2 && mdl_c >= 2) begin
                nx_valid = 1'b1;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        nx_win[(8 - (3*dr + dc))*24 +: 24] = img[mdl_r-2+dr][mdl_c-2+dc];
            end
            if (mdl_r == H-1 && mdl_c == W-1) begin
                nx_done    = 1'b1;
                mdl_active = 1'b0;
            end
            mdl_c++;
            if (mdl_c == W) begin
                mdl_c = 0;
                mdl_r++;
            end
        end
        @(posedge clk);
        #1;
        exp_valid = nx_valid;
        exp_done  = nx_done;
        exp_win   = nx_win;
        chk_en    = 1'b1;
    endtask

    // Send raster pixels first..first+count-1; sof on the first one if requested.
    task automatic send(input int first, input int count, input logic sof,
                        input logic [23:0] x, input logic gaps);
        for (int k = first; k < first + count; k++) begin
            step(1'b0, 1'b1, sof && (k == first), pixel(k / W, k % W, x));
            if (gaps) step(1'b0, 1'b0, 1'b0, 24'hDEAD00 + 24'(k));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 24'h5A5A5A);
    endtask

    task automatic clear_counts();
        n_win_seen  = 0;
        n_done_seen = 0;
        first_win   = '0;
        last_win    = '0;
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_win = '0;
        mdl_active = 1'b0; mdl_r = 0; mdl_c = 0;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 24'd0;
        clear_counts();

        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b1, 1'b1, 24'h123456);
        chk("reset_window", RGB_window, 216'd0);
        chk("reset_valid",  {215'd0, out_valid},  216'd0);
        chk("reset_done",   {215'd0, frame_done}, 216'd0);
        idle(2);

        // Continuous 4x4 frame.
        clear_counts();
        idle(2);
        send(0, 16, 1'b1, 24'h000000, 1'b0);
        idle(3);
        chk("s1_windows", 216'(n_win_seen),  216'd4);
        chk("s1_done",    216'(n_done_seen), 216'd1);
        chk("s1_first_a", 216'(first_win[215:192]), 216'h000000);
        chk("s1_first_e", 216'(first_win[119:96]),  216'h010105);
        chk("s1_first_i", 216'(first_win[23:0]),    216'h02020A);
        chk("s1_last_i",  216'(last_win[23:0]),     216'h03030F);

        // Same frame with bubbles between accepted pixels.
        clear_counts();
        send(0, 16, 1'b1, 24'h000000, 1'b1);
        idle(3);
        chk("s2_windows", 216'(n_win_seen),  216'd4);
        chk("s2_done",    216'(n_done_seen), 216'd1);
        chk("s2_first_e", 216'(first_win[119:96]), 216'h010105);
        chk("s2_first_i", 216'(first_win[23:0]),   216'h02020A);

        // Restart at pixel (2,1), then a full frame with different data.
        clear_counts();
        send(0, 9, 1'b1, 24'h000000, 1'b0);
        send(0, 16, 1'b1, 24'h111111, 1'b0);
        idle(3);
        chk("s3_windows", 216'(n_win_seen),  216'd4);
        chk("s3_done",    216'(n_done_seen), 216'd1);
        chk("s3_first_e", 216'(first_win[119:96]), 216'h101014);

        // Reset at pixel (3,0); the rest of the frame arrives without sof.
        clear_counts();
        send(0, 12, 1'b1, 24'h000000, 1'b0);
        step(1'b1, 1'b1, 1'b0, pixel(3, 0, 24'h000000));
        chk("s4_rst_window", RGB_window, 216'd0);
        chk("s4_rst_valid",  {215'd0, out_valid}, 216'd0);
        send(13, 3, 1'b0, 24'h000000, 1'b0);
        idle(3);
        chk("s4_windows", 216'(n_win_seen),  216'd2);
        chk("s4_done",    216'(n_done_seen), 216'd0);

        // Back-to-back frames, second sof lands in the DONE cycle.
        clear_counts();
        send(0, 16, 1'b1, 24'h000000, 1'b0);
        send(0, 16, 1'b1, 24'hA0A0A0, 1'b0);
        idle(3);
        chk("s5_windows", 216'(n_win_seen),  216'd8);
        chk("s5_done",    216'(n_done_seen), 216'd2);
        chk("s5_last_a",  216'(last_win[215:192]), 216'hA1A1A5);
        chk("s5_last_i",  216'(last_win[23:0]),    216'hA3A3AF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
